imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL: Clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL: Clrn  in  1  reset, asynchronous, active-low.
REQ-003 SHALL: Start  in  1  one-cycle pulse that begins a load session; honoured only in IDLE or DONE.
REQ-004 SHALL: Word_Count  in  6  number of 32-bit instructions to load; sampled on accepted Start.
REQ-005 SHALL: In_Valid  in  1  source presents a byte on In_Byte.
REQ-006 SHALL: In_Byte  in  8  instruction byte stream, most significant byte first.
REQ-007 SHALL: In_Ready  out  1  loader can accept a byte this cycle.
REQ-008 SHALL: Wr_En  out  1  one-cycle write strobe to the instruction memory write port.
REQ-009 SHALL: Wr_Addr  out  32  byte address of the word being written; bits [1:0] always 0, word index on [6:2].
REQ-010 SHALL: Wr_Data  out  32  assembled instruction word.
REQ-011 SHALL: Busy  out  1  session in progress (RECV or WRITE).
REQ-012 SHALL: Cpu_Hold  out  1  equals Busy; stalls the CPU PC while instruction memory is being rewritten.
REQ-013 SHALL: Done  out  1  high in DONE state until the next accepted Start or reset.
REQ-014 SHALL: Checksum  out  8  modulo-256 sum of all bytes accepted in the current session.

Function
REQ-015 SHALL: implement states IDLE, RECV, WRITE, DONE.
REQ-016 SHALL: on accepted Start: clear word index, byte counter and Checksum; latch count; go to RECV.
REQ-017 SHALL: latched count = Word_Count if 1..32; Word_Count > 32 clamped to 32; Word_Count = 0 goes directly to DONE with no writes.
REQ-018 SHALL: In_Ready = 1 only in RECV; a byte is accepted when In_Valid && In_Ready.
REQ-019 SHALL: accepted bytes shift into the word register left by 8 (first byte ends in [31:24]); byte counter increments modulo 4.
REQ-020 SHALL: acceptance of the 4th byte moves RECV -> WRITE on the same edge.
REQ-021 SHALL: in WRITE, for exactly one cycle: Wr_En = 1, Wr_Addr = {25'b0, word_index[4:0], 2'b00}, Wr_Data = assembled word; In_Ready = 0.
REQ-022 SHALL: after WRITE, increment word index; if new index == latched count go to DONE, else return to RECV.
REQ-023 SHALL: In_Valid low in RECV hold all state (no timeout).
REQ-024 SHALL: Start asserted in RECV or WRITE is ignored.
REQ-025 SHALL: Start in DONE restarts a session identically to IDLE; Done deasserts on that edge.
REQ-026 SHALL: Wr_En = 0 in all states other than WRITE; Wr_Addr/Wr_Data hold last value when Wr_En = 0.
REQ-027 SHALL: Checksum updates on every accepted byte, wrapping at 256, and holds in DONE.
REQ-028 SHALL: a full 32-word load produces writes to addresses 0x00..0x7C in order, one per word, no address wrap within a session.
REQ-029 SHALL: a word costs at minimum 5 cycles (4 accept + 1 write); Done rises the cycle after the final WRITE.

Reset
REQ-030 SHALL: Clrn low forces immediately, independent of Clk: state IDLE, In_Ready 0, Wr_En 0, Wr_Addr 0, Wr_Data 0, Busy 0, Cpu_Hold 0, Done 0, Checksum 0, counters 0.
REQ-031 SHALL: reset mid-session abandons the partial word with no further write; words already written are not rolled back.
REQ-032 SHALL: after Clrn release, loader waits in IDLE for Start.

Verification
REQ-033 SHALL: Start, Word_Count=1, bytes 20 01 00 08 back-to-back -> single Wr_En, Wr_Addr 0x00, Wr_Data 0x20010008, Checksum 0x29, Done next cycle.
REQ-034 SHALL: Word_Count=3, bytes 20010008 3402000c 00411822 with random In_Valid gaps -> writes to 0x00, 0x04, 0x08 with those words in order, no extra Wr_En.
REQ-035 SHALL: Word_Count=40, 32 words streamed -> last write at 0x7C, Done after 32nd word, In_Ready low afterwards.
REQ-036 SHALL: Word_Count=0 -> Done on the cycle after Start, no Wr_En, In_Ready never high.
REQ-037 SHALL: Clrn pulsed low after 2 bytes of word 1 in a 2-word session -> all outputs 0 asynchronously, no write of word 1; subsequent Start, Word_Count=1 loads correctly to 0x00.
REQ-038 SHALL: Start pulsed during RECV of a 2-word session -> ignored; both words written to 0x00 and 0x04, and Checksum equals the sum of all 8 bytes modulo 256.

Source files
------------

// File: rtl/imem_loader.sv
// Instruction memory loader: receives a big-endian byte stream, assembles
// 32-bit words and writes them to consecutive word addresses of the
// instruction memory while holding the CPU.
module imem_loader (
  input  logic        clk,
  input  logic        clrn,
  input  logic        start,
  input  logic [5:0]  word_count,
  input  logic        in_valid,
  input  logic [7:0]  in_byte,
  output logic        in_ready,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        busy,
  output logic        cpu_hold,
  output logic        done,
  output logic [7:0]  checksum
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RECV  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t      state_reg;
  state_t      state_next;

  logic [5:0]  count_reg;     // number of words to load this session (0..32)
  logic [5:0]  word_idx_reg;  // index of the word currently being assembled
  logic [1:0]  byte_cnt_reg;  // bytes of the current word received so far
  logic [23:0] word_reg;      // first three bytes of the word in progress
  logic [7:0]  checksum_reg;
  logic [31:0] wr_addr_reg;
  logic [31:0] wr_data_reg;

  logic        start_ok;
  logic        accept;
  logic        last_byte;
  logic [5:0]  count_clamped;
  logic [5:0]  word_idx_inc;

  // Start is only honoured between sessions; a byte moves only while receiving.
  assign start_ok      = start && ((state_reg == S_IDLE) || (state_reg == S_DONE));
  assign accept        = in_valid && (state_reg == S_RECV);
  assign last_byte     = accept && (byte_cnt_reg == 2'd3);
  assign count_clamped = (word_count > 6'd32) ? 6'd32 : word_count;
  assign word_idx_inc  = word_idx_reg + 6'd1;

  // State register.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: a zero-length session goes straight to DONE.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_next = (count_clamped == 6'd0) ? S_DONE : S_RECV;
        end
      end
      S_RECV: begin
        if (last_byte) begin
          state_next = S_WRITE;
        end
      end
      S_WRITE: begin
        state_next = (word_idx_inc == count_reg) ? S_DONE : S_RECV;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Outputs decoded from the current state; the CPU is held for the whole session.
  always_comb begin
    in_ready = (state_reg == S_RECV);
    wr_en    = (state_reg == S_WRITE);
    busy     = (state_reg == S_RECV) || (state_reg == S_WRITE);
    cpu_hold = busy;
    done     = (state_reg == S_DONE);
  end

  // Datapath: session setup, byte assembly, checksum and the write-port registers.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      count_reg    <= 6'd0;
      word_idx_reg <= 6'd0;
      byte_cnt_reg <= 2'd0;
      word_reg     <= 24'd0;
      checksum_reg <= 8'd0;
      wr_addr_reg  <= 32'd0;
      wr_data_reg  <= 32'd0;
    end else begin
      if (start_ok) begin
        count_reg    <= count_clamped;
        word_idx_reg <= 6'd0;
        byte_cnt_reg <= 2'd0;
        checksum_reg <= 8'd0;
      end
      if (accept) begin
        word_reg     <= {word_reg[15:0], in_byte};
        byte_cnt_reg <= byte_cnt_reg + 2'd1;
        checksum_reg <= checksum_reg + in_byte;
      end
      // The completed word and its address are captured as WRITE is entered,
      // so they are stable during the strobe and hold afterwards.
      if (last_byte) begin
        wr_data_reg <= {word_reg, in_byte};
        wr_addr_reg <= {25'd0, word_idx_reg[4:0], 2'b00};
      end
      if (state_reg == S_WRITE) begin
        word_idx_reg <= word_idx_inc;
      end
    end
  end

  assign wr_addr  = wr_addr_reg;
  assign wr_data  = wr_data_reg;
  assign checksum = checksum_reg;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: the stimulus side pushes the expected
// (address, word) of each word it streams; a monitor pops one entry per
// write strobe. Session-level results are checked against a small model.
module tb_imem_loader;

  logic        clk;
  logic        clrn;
  logic        start;
  logic [5:0]  word_count;
  logic        in_valid;
  logic [7:0]  in_byte;
  logic        in_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        busy;
  logic        cpu_hold;
  logic        done;
  logic [7:0]  checksum;

  imem_loader dut (
    .clk        (clk),
    .clrn       (clrn),
    .start      (start),
    .word_count (word_count),
    .in_valid   (in_valid),
    .in_byte    (in_byte),
    .in_ready   (in_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .checksum   (checksum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int writes_seen = 0;
  int last_wr_cyc = -10;
  logic [7:0]  sess_sum;
  logic [63:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%08h", name, act);
    end
  endtask

  // Monitor: every write strobe must match the oldest outstanding word.
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (clrn === 1'b1 && wr_en === 1'b1) begin
        writes_seen++;
        last_wr_cyc = cyc;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_write: got addr 0x%08h data 0x%08h expected no write", wr_addr, wr_data);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", wr_addr, e[63:32]);
          chk("wr_data", wr_data, e[31:0]);
        end
      end
    end
  end

  task automatic check_zero(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    chk({tag, "_wr_en"},    32'(wr_en),    32'd0);
    chk({tag, "_wr_addr"},  wr_addr,       32'd0);
    chk({tag, "_wr_data"},  wr_data,       32'd0);
    chk({tag, "_busy"},     32'(busy),     32'd0);
    chk({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd0);
    chk({tag, "_done"},     32'(done),     32'd0);
    chk({tag, "_checksum"}, 32'(checksum), 32'd0);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear without a clock edge.
  task automatic do_reset(input string tag);
    @(posedge clk);
    #3 clrn = 1'b0;
    #1 check_zero(tag);
    repeat (2) @(posedge clk);
    @(negedge clk);
    clrn = 1'b1;
  endtask

  task automatic start_session(input int n);
    int nc;
    nc = (n > 32) ? 32 : n;
    @(negedge clk);
    word_count = 6'(n);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    word_count = 6'($urandom);
    sess_sum = 8'd0;
    writes_seen = 0;
    @(negedge clk);
    if (nc == 0) begin
      chk("start0_done",     32'(done),     32'd1);
      chk("start0_in_ready", 32'(in_ready), 32'd0);
      chk("start0_busy",     32'(busy),     32'd0);
    end else begin
      chk("start_done",     32'(done),     32'd0);
      chk("start_busy",     32'(busy),     32'd1);
      chk("start_cpu_hold", 32'(cpu_hold), 32'd1);
      chk("start_in_ready", 32'(in_ready), 32'd1);
      chk("start_checksum", 32'(checksum), 32'd0);
    end
  endtask

  // Present one byte; with gaps, in_valid is randomly withheld while ready,
  // and junk is offered while the loader is not ready.
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int waited;
    bit sent;
    waited = 0;
    sent = 1'b0;
    while (!sent && waited < 200) begin
      @(negedge clk);
      if (in_ready === 1'b1 && !(gaps && $urandom_range(0, 2) == 0)) begin
        in_valid = 1'b1;
        in_byte  = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_byte  = 8'($urandom);
        sess_sum = sess_sum + b;
        sent = 1'b1;
      end else begin
        in_valid = (in_ready === 1'b1) ? 1'b0 : 1'($urandom_range(0, 1));
        in_byte  = 8'($urandom);
        waited++;
      end
    end
    if (!sent) begin
      in_valid = 1'b0;
      checks++;
      errors++;
      $display("FAIL byte_accept_timeout: got in_ready=%0d expected acceptance within 200 cycles", in_ready);
    end
  endtask

  task automatic send_word(input int idx, input logic [31:0] data, input bit gaps);
    exp_q.push_back({32'(idx * 4), data});
    for (int k = 0; k < 4; k++) send_byte(data[31 - 8 * k -: 8], gaps);
  endtask

  task automatic finish_session(input string tag, input int exp_writes);
    int waited;
    waited = 0;
    while (done !== 1'b1 && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
    if (exp_writes > 0) chk({tag, "_done_cycle"}, 32'(cyc), 32'(last_wr_cyc + 1));
    chk({tag, "_writes"},   32'(writes_seen),  32'(exp_writes));
    chk({tag, "_pending"},  32'(exp_q.size()), 32'd0);
    chk({tag, "_checksum"}, 32'(checksum),     32'(sess_sum));
    chk({tag, "_in_ready"}, 32'(in_ready),     32'd0);
    chk({tag, "_busy"},     32'(busy),         32'd0);
    chk({tag, "_cpu_hold"}, 32'(cpu_hold),     32'd0);
    repeat (3) @(negedge clk);
    chk({tag, "_cs_hold"},   32'(checksum), 32'(sess_sum));
    chk({tag, "_done_hold"}, 32'(done),     32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] w [3];
    logic [31:0] a, b;
    int n;
    clrn = 1'b1;
    start = 1'b0;
    word_count = 6'd0;
    in_valid = 1'b0;
    in_byte = 8'd0;
    sess_sum = 8'd0;
    #2 clrn = 1'b0;
    #1 check_zero("por");
    repeat (2) @(posedge clk);
    @(negedge clk);
    clrn = 1'b1;
    @(negedge clk);
    chk("idle_done", 32'(done), 32'd0);
    chk("idle_in_ready", 32'(in_ready), 32'd0);

    // Single word, back-to-back bytes.
    start_session(1);
    send_word(0, 32'h2001_0008, 1'b0);
    finish_session("one_word", 1);
    chk("one_word_cs_const", 32'(checksum), 32'h29);

    // Three words with random gaps, restarted from DONE.
    w[0] = 32'h2001_0008; w[1] = 32'h3402_000c; w[2] = 32'h0041_1822;
    start_session(3);
    for (int i = 0; i < 3; i++) send_word(i, w[i], 1'b1);
    finish_session("three_words", 3);

    // Oversized count clamps to 32 words covering 0x00..0x7C.
    start_session(40);
    for (int i = 0; i < 32; i++) send_word(i, $urandom, 1'b0);
    finish_session("clamp40", 32);
    chk("clamp40_last_addr", wr_addr, 32'h7c);

    // Zero-length session.
    start_session(0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("zero_in_ready", 32'(in_ready), 32'd0);
    end
    chk("zero_writes", 32'(writes_seen), 32'd0);

    // Reset after two bytes of the first word of a two-word session.
    start_session(2);
    send_byte(8'hde, 1'b0);
    send_byte(8'had, 1'b0);
    do_reset("midreset");
    @(negedge clk);
    chk("midreset_idle_in_ready", 32'(in_ready), 32'd0);
    chk("midreset_idle_done", 32'(done), 32'd0);
    chk("midreset_writes", 32'(writes_seen), 32'd0);
    start_session(1);
    send_word(0, 32'hcafe_f00d, 1'b1);
    finish_session("after_reset", 1);

    // Start pulsed while receiving is ignored.
    a = $urandom; b = $urandom;
    start_session(2);
    exp_q.push_back({32'd0, a});
    exp_q.push_back({32'd4, b});
    send_byte(a[31:24], 1'b0);
    send_byte(a[23:16], 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("ignored_start_in_ready", 32'(in_ready), 32'd1);
    word_count = 6'd5;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("ignored_start_busy", 32'(busy), 32'd1);
    send_byte(a[15:8], 1'b0);
    send_byte(a[7:0], 1'b0);
    for (int k = 0; k < 4; k++) send_byte(b[31 - 8 * k -: 8], 1'b1);
    finish_session("ignored_start", 2);
    chk("ignored_start_cs_sum", 32'(checksum),
        32'(8'(a[31:24] + a[23:16] + a[15:8] + a[7:0] + b[31:24] + b[23:16] + b[15:8] + b[7:0])));

    // Random short sessions.
    for (int s = 0; s < 4; s++) begin
      n = $urandom_range(1, 6);
      start_session(n);
      for (int i = 0; i < n; i++) send_word(i, $urandom, 1'b1);
      finish_session("random", n);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
